muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have parameter XLEN, default 32: operand/result width, even, >= 8; all latencies below are in terms of XLEN.
REQ-002 The block SHALL have port clk, input, 1: single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-004 The block SHALL have port start, input, 1: request strobe, sampled only in IDLE.
REQ-005 The block SHALL have port funct3, input, 3: operation select (000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU).
REQ-006 The block SHALL have ports in1 and in2, input, XLEN each: rs1 and rs2 operands.
REQ-007 The block SHALL have port busy, output, 1: operation in progress.
REQ-008 The block SHALL have port done, output, 1: one-cycle completion pulse, registered.
REQ-009 The block SHALL have port result, output, XLEN: registered result of the last completed operation.
REQ-010 The block SHALL have port zero, output, 1: combinational flag, high when result == 0.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, CALC and FINAL.
REQ-012 In IDLE, start=1 at a rising edge SHALL latch in1, in2 and funct3, clear the iteration counter and move to CALC.
REQ-013 While in CALC or FINAL, the block SHALL ignore start, in1, in2 and funct3; no queuing and no abort.
REQ-014 CALC SHALL perform exactly one shift-add (multiply) or restoring-subtract (divide) step per cycle on operand magnitudes, for XLEN cycles, then move to FINAL.
REQ-015 FINAL SHALL last one cycle; it applies sign correction and special cases, writes result, pulses done and returns to IDLE.
REQ-016 Latency SHALL be fixed: done is high after edge XLEN+1 counted from the edge that sampled start (33 for XLEN=32), for exactly one cycle, independent of operand values.
REQ-017 busy SHALL be high exactly while the state is CALC or FINAL; busy and done are never high together.
REQ-018 result SHALL hold its value from the done edge until the next FINAL write.
REQ-019 start high in the same cycle as done SHALL be accepted, giving back-to-back operations with one IDLE cycle between them.
REQ-020 MUL SHALL return the low XLEN bits of the 2*XLEN-bit product; MULH, MULHSU and MULHU return the high XLEN bits, with operands treated signed x signed, signed(in1) x unsigned(in2), and unsigned x unsigned respectively.
REQ-021 DIV and DIVU SHALL return the quotient truncated toward zero; REM and REMU return the remainder, whose sign equals the dividend's sign.
REQ-022 When the divisor is 0, DIV and DIVU SHALL return all ones, and REM and REMU SHALL return in1.
REQ-023 For signed overflow (in1 = most-negative value, in2 = all ones), DIV SHALL return in1 and REM SHALL return 0.
REQ-024 The special cases in REQ-022 and REQ-023 SHALL still take the full latency of REQ-016.

Reset
REQ-025 rst_n low SHALL immediately, without waiting for clk, force: state IDLE, busy=0, done=0, result=0, zero=1, and iteration counter 0.
REQ-026 Reset asserted mid-operation SHALL discard the operation; no done is produced for it.
REQ-027 The first start after rst_n deasserts SHALL be sampled no earlier than the first rising edge with rst_n high.

Verification
REQ-028 The bench SHALL check MUL with in1=7, in2=0xFFFFFFFD (-3) -> result 0xFFFFFFEB, done exactly 33 edges after start.
REQ-029 The bench SHALL check MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 0x00000002 -> 0xFFFFFFFF.
REQ-030 The bench SHALL check DIV -7/2 -> 0xFFFFFFFD and REM -7%2 -> 0xFFFFFFFF; DIVU 100/0 -> 0xFFFFFFFF and REMU 100/0 -> 0x00000064.
REQ-031 The bench SHALL check DIV 0x80000000/0xFFFFFFFF -> 0x80000000, and REM for the same operands -> 0x00000000 with zero=1.
REQ-032 The bench SHALL pulse rst_n low at cycle 10 of a DIV: busy and done drop to 0 at once, result=0, and no done pulse follows; a fresh DIVU 9/3 afterwards -> result 3.
REQ-033 The bench SHALL assert start again in the done cycle, and also toggle start and operands while busy: the second op is accepted with one IDLE gap, the mid-op toggles have no effect, and the first result is unchanged.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: one shift-add or restoring-subtract step per
// cycle on operand magnitudes, with sign correction and special cases applied in FINAL.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] in1,
  input  logic [XLEN-1:0] in2,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic [1:0]      dbg_state
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FINAL = 2'd2
  } state_t;

  // Handshake: start is only looked at while busy=0; done is a one-cycle pulse
  // in the first IDLE cycle after FINAL, and result is stable from then on.

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_f3;
  logic            r_neg;
  logic            r_a_neg;
  logic            r_div_zero;
  logic [XLEN-1:0] r_in1;
  logic [XLEN-1:0] r_mcand;
  logic [XLEN-1:0] r_hi;
  logic [XLEN-1:0] r_lo;
  logic [XLEN-1:0] r_result;
  logic            r_done;

  logic            w_sgn_a;
  logic            w_sgn_b;
  logic            w_a_neg;
  logic            w_b_neg;
  logic [XLEN-1:0] w_a_mag;
  logic [XLEN-1:0] w_b_mag;
  logic [XLEN:0]   w_sum;
  logic [XLEN:0]   w_shift;
  logic [XLEN:0]   w_diff;
  logic [2*XLEN-1:0] w_prod;
  logic [2*XLEN-1:0] w_prod_s;
  logic [XLEN-1:0] w_quo_s;
  logic [XLEN-1:0] w_rem_s;
  logic [XLEN-1:0] w_final;

  // Signedness of each operand: MULH/MULHSU/DIV/REM treat rs1 as signed, MULH/DIV/REM rs2.
  assign w_sgn_a = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                   (funct3 == 3'b100) || (funct3 == 3'b110);
  assign w_sgn_b = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
  assign w_a_neg = w_sgn_a & in1[XLEN-1];
  assign w_b_neg = w_sgn_b & in2[XLEN-1];
  assign w_a_mag = w_a_neg ? (~in1 + 1'b1) : in1;
  assign w_b_mag = w_b_neg ? (~in2 + 1'b1) : in2;

  assign w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mcand} : '0);
  assign w_shift = {r_hi, r_lo[XLEN-1]};
  assign w_diff  = w_shift - {1'b0, r_mcand};

  assign w_prod   = {r_hi, r_lo};
  assign w_prod_s = r_neg ? (~w_prod + 1'b1) : w_prod;
  assign w_quo_s  = r_neg ? (~r_lo + 1'b1) : r_lo;
  assign w_rem_s  = r_a_neg ? (~r_hi + 1'b1) : r_hi;

  always_comb begin
    w_final = '0;
    case (r_f3)
      3'b000:          w_final = w_prod_s[XLEN-1:0];
      3'b001, 3'b010,
      3'b011:          w_final = w_prod_s[2*XLEN-1:XLEN];
      3'b100, 3'b101:  w_final = r_div_zero ? '1 : w_quo_s;
      default:         w_final = r_div_zero ? r_in1 : w_rem_s;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = CALC;
      CALC:    if (r_cnt == CW'(XLEN-1)) w_next = FINAL;
      FINAL:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_f3       <= '0;
      r_neg      <= 1'b0;
      r_a_neg    <= 1'b0;
      r_div_zero <= 1'b0;
      r_in1      <= '0;
      r_mcand    <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_result   <= '0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_cnt      <= '0;
            r_f3       <= funct3;
            r_neg      <= w_a_neg ^ w_b_neg;
            r_a_neg    <= w_a_neg;
            r_div_zero <= (in2 == '0);
            r_in1      <= in1;
            r_hi       <= '0;
            // Multiply shifts the multiplier out of r_lo; divide shifts the dividend out.
            r_mcand    <= funct3[2] ? w_b_mag : w_a_mag;
            r_lo       <= funct3[2] ? w_a_mag : w_b_mag;
          end
        end
        CALC: begin
          r_cnt <= r_cnt + 1'b1;
          if (!r_f3[2]) begin
            r_hi <= w_sum[XLEN:1];
            r_lo <= {w_sum[0], r_lo[XLEN-1:1]};
          end else if (!w_diff[XLEN]) begin
            r_hi <= w_diff[XLEN-1:0];
            r_lo <= {r_lo[XLEN-2:0], 1'b1};
          end else begin
            r_hi <= w_shift[XLEN-1:0];
            r_lo <= {r_lo[XLEN-2:0], 1'b0};
          end
        end
        FINAL: begin
          r_result <= w_final;
          r_done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy      = (r_state == CALC) || (r_state == FINAL);
  assign done      = r_done;
  assign result    = r_result;
  assign zero      = (r_result == '0);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and randomized bench for muldiv_unit (XLEN=32) with a 64-bit arithmetic reference.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] in1;
  logic [31:0] in2;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        zero;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;
  logic [31:0] last_exp = '0;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3),
    .in1(in1), .in2(in2), .busy(busy), .done(done),
    .result(result), .zero(zero), .dbg_state(dbg_state)
  );

  function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a,
                                         input logic [31:0] b);
    longint          sa, sb, p;
    longint unsigned ua, ub, up;
    int              ia, ib, q;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    ia = $signed(a);
    ib = $signed(b);
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin up = ua * ub; return up[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        q = ia / ib; return q;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        q = ia % ib; return q;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic logic [31:0] pick();
    logic [31:0] specials [5] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 4)];
    if ($urandom_range(0, 3) == 0) return $urandom_range(0, 20);
    return $urandom;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issues one op starting at the next negedge; returns at #1 after the done edge.
  task automatic do_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input bit toggle);
    int lat;
    bit clash;
    @(negedge clk);
    start = 1'b1; funct3 = f; in1 = a; in2 = b;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    clash = 1'b0;
    while (done !== 1'b1 && lat < 100) begin
      if (toggle) begin
        if (lat < 30) begin
          start = 1'($urandom_range(0, 1)); in1 = $urandom; in2 = $urandom;
          funct3 = 3'($urandom_range(0, 7));
        end else start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
      if (busy === 1'b1 && done === 1'b1) clash = 1'b1;
      if (lat == 16) begin
        check({tag, " hold"}, result, last_exp);
        check({tag, " busy_mid"}, 32'(busy), 32'd1);
      end
    end
    check({tag, " latency"}, lat, 33);
    check({tag, " result"}, result, exp);
    check({tag, " zero"}, 32'(zero), 32'(exp == 0));
    check({tag, " busy_done"}, 32'(busy), 32'd0);
    check({tag, " clash"}, 32'(clash), 32'd0);
    last_exp = exp;
  endtask

  initial begin
    logic [2:0]  f;
    logic [31:0] a, b;
    bit seen;
    rst_n = 1'b0; start = 1'b0; funct3 = '0; in1 = '0; in2 = '0;
    #1;
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst result", result, 32'd0);
    check("rst zero", 32'(zero), 32'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    do_op("mul",    3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);
    do_op("mulh",   3'b001, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 1'b0);
    do_op("mulhu",  3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
    do_op("mulhsu", 3'b010, 32'hFFFF_FFFF,  32'h0000_0002, 32'hFFFF_FFFF, 1'b0);
    do_op("div",    3'b100, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 1'b0);
    do_op("rem",    3'b110, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 1'b0);
    do_op("divu0",  3'b101, 32'd100,        32'd0,         32'hFFFF_FFFF, 1'b0);
    do_op("remu0",  3'b111, 32'd100,        32'd0,         32'h0000_0064, 1'b0);
    do_op("divovf", 3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
    do_op("removf", 3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 1'b0);

    // Back-to-back pair; the second op sees random start/operand toggles while busy.
    do_op("b2b_first",  3'b000, 32'd1234,   32'd5678,      32'd7006652,   1'b0);
    do_op("b2b_second", 3'b101, 32'd1000,   32'd7,         32'd142,       1'b1);

    // Reset mid-DIV: everything clears asynchronously and no done follows.
    do_op("pre_rst", 3'b000, 32'd3, 32'd5, 32'd15, 1'b0);
    @(negedge clk);
    start = 1'b1; funct3 = 3'b100; in1 = 32'd1000; in2 = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst done", 32'(done), 32'd0);
    check("midrst result", result, 32'd0);
    check("midrst zero", 32'(zero), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    last_exp = '0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done === 1'b1) seen = 1'b1;
    end
    check("midrst no_done", 32'(seen), 32'd0);
    do_op("divu_after_rst", 3'b101, 32'd9, 32'd3, 32'd3, 1'b0);

    for (int i = 0; i < 48; i++) begin
      f = 3'($urandom_range(0, 7));
      a = pick();
      b = pick();
      do_op($sformatf("rand%0d_f%0d", i, f), f, a, b, ref_op(f, a, b), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
